cordic_iterative_engine: RTL and testbench
==========================================

CORDIC_ITERATIVE_ENGINE -- requirements
Module: cordic_iterative_engine

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of x/y/z in bits (16..32).
REQ-002 Parameter FRAC, default 28, fractional bits of x/y/z, signed fixed point; FRAC <= 30 and FRAC <= WIDTH-3.
REQ-003 Parameter ITERATIONS, default 24, base micro-rotation count (1..WIDTH-2).
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_valid  in  1  operand present.
REQ-007 in_ready  out  1  engine can accept operands.
REQ-008 mode  in  2  00 LINEAR, 10 CIRCULAR, 11 HYPERBOLIC; 01 treated as LINEAR.
REQ-009 vectoring  in  1  0 rotation (drive z to 0), 1 vectoring (drive y to 0).
REQ-010 x_in, y_in, z_in  in  WIDTH each  signed operands.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 x_out, y_out, z_out  out  WIDTH each  signed results, registered.
REQ-014 busy  out  1  high in ITERATE or DONE.

Function
REQ-015 States: IDLE, ITERATE, DONE; IDLE->ITERATE on accept, ITERATE->DONE after last step, DONE->IDLE on out_valid&out_ready.
REQ-016 in_ready is high only in IDLE; accept = in_valid & in_ready; in_valid outside IDLE is ignored, with no side effects.
REQ-017 On accept, mode, vectoring and operands are captured; later input changes do not affect the operation.
REQ-018 CIRCULAR pre-correction at capture: rotation with z > pi/2 -> (x,y,z) := (-y, x, z-pi/2); z < -pi/2 -> (y, -x, z+pi/2); vectoring with x < 0 -> y >= 0 ? (y, -x, z+pi/2) : (-y, x, z-pi/2).
REQ-019 Step i: d = +1 if (rotation and z >= 0) or (vectoring and y < 0), else -1.
REQ-020 Step update: x' = x - m*d*(y>>>k); y' = y + d*(x>>>k); z' = z - d*e(k); m = 1 circular, 0 linear, -1 hyperbolic; >>> is arithmetic shift.
REQ-021 Shift index k: circular and linear run k = 0..ITERATIONS-1; hyperbolic runs k = 1..ITERATIONS, executing k = 4, 13 and 40 twice when within range.
REQ-022 e(k) = atan(2^-k), 2^-k or atanh(2^-k) from internal 32-bit tables with 30 fractional bits, right-shifted arithmetically by (30-FRAC).
REQ-023 Total steps S = ITERATIONS for circular/linear, ITERATIONS + repeats for hyperbolic; one step per clock.
REQ-024 out_valid rises S clocks after the accepting edge and holds, with outputs stable, until out_ready is sampled high.
REQ-025 out_ready high in the same cycle out_valid rises completes the transfer that edge; in_ready returns high the following cycle.
REQ-026 Arithmetic wraps modulo 2^WIDTH; no saturation; CORDIC gain is not compensated (circular ~1.64676, hyperbolic ~0.82816).
REQ-027 Outputs change only on entry to DONE; x_out/y_out/z_out hold the last result while in IDLE and ITERATE.

Reset
REQ-028 Reset, whether idle or mid-operation, forces IDLE and clears the step counter and datapath registers; x_out, y_out, z_out = 0, out_valid = 0, busy = 0, in_ready = 1 in the first cycle after deassertion.
REQ-029 An operation interrupted by reset produces no result.

Verification (WIDTH=32, FRAC=28, ITERATIONS=24, tolerance 2^-20)
REQ-030 CIRCULAR rotation x=1.0, y=0, z=pi/4 -> x_out ~= y_out ~= 1.16443, z_out ~= 0, with out_valid exactly 24 clocks after accept.
REQ-031 CIRCULAR vectoring x=-1.0, y=1.0, z=0 -> pre-correction applied, x_out ~= 2.32887, y_out ~= 0, z_out ~= 3pi/4 (2.35619).
REQ-032 HYPERBOLIC rotation x=1.0, y=0, z=0.5 -> x_out ~= 0.93386, y_out ~= 0.43155; out_valid 26 clocks after accept (repeats at k=4 and k=13).
REQ-033 LINEAR rotation x=0.5, y=0, z=0.25 -> y_out ~= 0.125, x_out = 0.5 exact; LINEAR vectoring x=0.5, y=0.125 -> z_out ~= 0.25.
REQ-034 Backpressure: out_ready low for 10 cycles after out_valid -> outputs and out_valid held, in_ready low, and in_valid pulses ignored; release -> one transfer, then in_ready high next cycle.
REQ-035 Reset asserted at step 10 -> all outputs 0 immediately, no out_valid; a new operation accepted after deassertion completes correctly.

Source files
------------

// File: rtl/cordic_iterative_engine.sv
// Iterative CORDIC engine: linear, circular and hyperbolic coordinate systems in rotation
// or vectoring mode, one micro-rotation per clock, uncompensated gain, wrapping arithmetic.
module cordic_iterative_engine #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 28,
    parameter int ITERATIONS = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic                    vectoring,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    busy
);

    localparam int TAB_SHIFT = 30 - FRAC;
    localparam logic [5:0] K_LAST_CL  = 6'(ITERATIONS - 1);
    localparam logic [5:0] K_LAST_HYP = 6'(ITERATIONS);
    localparam logic signed [31:0] HALF_PI_Q30 = 32'sh6487_ED51;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITERATE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_LINEAR,
        M_CIRCULAR,
        M_HYPERBOLIC
    } mode_t;

    // Angle tables are Q2.30; beyond k = 9 both functions round to exactly 2^-k.
    function automatic logic signed [31:0] atanQ30(input logic [5:0] k);
        case (k)
            6'd0:    return 32'sd843314857;
            6'd1:    return 32'sd497837829;
            6'd2:    return 32'sd263043837;
            6'd3:    return 32'sd133525159;
            6'd4:    return 32'sd67021687;
            6'd5:    return 32'sd33543516;
            6'd6:    return 32'sd16775851;
            6'd7:    return 32'sd8388437;
            6'd8:    return 32'sd4194283;
            6'd9:    return 32'sd2097149;
            default: return $signed(32'h4000_0000 >> k);
        endcase
    endfunction

    function automatic logic signed [31:0] atanhQ30(input logic [5:0] k);
        case (k)
            6'd0:    return 32'sd0;
            6'd1:    return 32'sd589812981;
            6'd2:    return 32'sd274247419;
            6'd3:    return 32'sd134923406;
            6'd4:    return 32'sd67196451;
            6'd5:    return 32'sd33565361;
            6'd6:    return 32'sd16778582;
            6'd7:    return 32'sd8388779;
            6'd8:    return 32'sd4194325;
            6'd9:    return 32'sd2097155;
            default: return $signed(32'h4000_0000 >> k);
        endcase
    endfunction

    state_t r_state;
    state_t w_nextState;
    mode_t  r_mode;
    mode_t  w_modeIn;

    logic                    r_vectoring;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;
    logic [5:0]              r_k;
    logic                    r_repeated;

    logic                    w_accept;
    logic signed [31:0]      w_halfPiFull;
    logic signed [WIDTH-1:0] w_halfPi;
    logic signed [WIDTH-1:0] w_xCap;
    logic signed [WIDTH-1:0] w_yCap;
    logic signed [WIDTH-1:0] w_zCap;

    logic signed [31:0]      w_tab;
    logic signed [31:0]      w_eFull;
    logic signed [WIDTH-1:0] w_e;
    logic signed [WIDTH-1:0] w_xShift;
    logic signed [WIDTH-1:0] w_yShift;
    logic                    w_dPos;
    logic signed [WIDTH-1:0] w_xNext;
    logic signed [WIDTH-1:0] w_yNext;
    logic signed [WIDTH-1:0] w_zNext;
    logic                    w_repeatNow;
    logic [5:0]              w_kLast;
    logic                    w_lastStep;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = in_valid && in_ready;

    assign w_halfPiFull = HALF_PI_Q30 >>> TAB_SHIFT;
    assign w_halfPi     = w_halfPiFull[WIDTH-1:0];

    always_comb begin
        w_modeIn = M_LINEAR;
        if (mode == 2'b10) begin
            w_modeIn = M_CIRCULAR;
        end else if (mode == 2'b11) begin
            w_modeIn = M_HYPERBOLIC;
        end
    end

    // Circular operands are folded into the +/- pi/2 convergence range before iterating.
    always_comb begin
        w_xCap = x_in;
        w_yCap = y_in;
        w_zCap = z_in;
        if (w_modeIn == M_CIRCULAR) begin
            if (!vectoring) begin
                if (z_in > w_halfPi) begin
                    w_xCap = -y_in;
                    w_yCap = x_in;
                    w_zCap = z_in - w_halfPi;
                end else if (z_in < -w_halfPi) begin
                    w_xCap = y_in;
                    w_yCap = -x_in;
                    w_zCap = z_in + w_halfPi;
                end
            end else if (x_in[WIDTH-1]) begin
                if (!y_in[WIDTH-1]) begin
                    w_xCap = y_in;
                    w_yCap = -x_in;
                    w_zCap = z_in + w_halfPi;
                end else begin
                    w_xCap = -y_in;
                    w_yCap = x_in;
                    w_zCap = z_in - w_halfPi;
                end
            end
        end
    end

    always_comb begin
        w_tab = 32'sd0;
        case (r_mode)
            M_CIRCULAR:   w_tab = atanQ30(r_k);
            M_HYPERBOLIC: w_tab = atanhQ30(r_k);
            default:      w_tab = $signed(32'h4000_0000 >> r_k);
        endcase
    end

    assign w_eFull  = w_tab >>> TAB_SHIFT;
    assign w_e      = w_eFull[WIDTH-1:0];
    assign w_xShift = r_x >>> r_k;
    assign w_yShift = r_y >>> r_k;
    assign w_dPos   = r_vectoring ? r_y[WIDTH-1] : !r_z[WIDTH-1];

    always_comb begin
        w_xNext = r_x;
        w_yNext = w_dPos ? (r_y + w_xShift) : (r_y - w_xShift);
        w_zNext = w_dPos ? (r_z - w_e) : (r_z + w_e);
        case (r_mode)
            M_CIRCULAR:   w_xNext = w_dPos ? (r_x - w_yShift) : (r_x + w_yShift);
            M_HYPERBOLIC: w_xNext = w_dPos ? (r_x + w_yShift) : (r_x - w_yShift);
            default:      w_xNext = r_x;
        endcase
    end

    // Hyperbolic shift indices 4, 13 and 40 run twice to keep the iteration convergent.
    assign w_repeatNow = (r_mode == M_HYPERBOLIC) && !r_repeated &&
                         ((r_k == 6'd4) || (r_k == 6'd13) || (r_k == 6'd40));
    assign w_kLast     = (r_mode == M_HYPERBOLIC) ? K_LAST_HYP : K_LAST_CL;
    assign w_lastStep  = (r_k == w_kLast) && !w_repeatNow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_nextState = S_ITERATE;
            S_ITERATE: if (w_lastStep) w_nextState = S_DONE;
            S_DONE:    if (out_ready) w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode      <= M_LINEAR;
            r_vectoring <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_k         <= '0;
            r_repeated  <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            z_out       <= '0;
        end else if (w_accept) begin
            r_mode      <= w_modeIn;
            r_vectoring <= vectoring;
            r_x         <= w_xCap;
            r_y         <= w_yCap;
            r_z         <= w_zCap;
            r_k         <= (w_modeIn == M_HYPERBOLIC) ? 6'd1 : 6'd0;
            r_repeated  <= 1'b0;
        end else if (r_state == S_ITERATE) begin
            r_x <= w_xNext;
            r_y <= w_yNext;
            r_z <= w_zNext;
            if (w_repeatNow) begin
                r_repeated <= 1'b1;
            end else begin
                r_k        <= r_k + 6'd1;
                r_repeated <= 1'b0;
            end
            if (w_lastStep) begin
                x_out <= w_xNext;
                y_out <= w_yNext;
                z_out <= w_zNext;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iterative_engine.sv
// Scoreboard bench for cordic_iterative_engine: ideal real-arithmetic reference model,
// directed spec cases, backpressure, mid-operation reset and randomized operations.
module tb_cordic_iterative_engine;

    localparam int  WIDTH      = 32;
    localparam int  FRAC       = 28;
    localparam int  ITERATIONS = 24;
    localparam real SCALE      = 268435456.0;
    localparam real PI         = 3.14159265358979;
    localparam real TOL_SPEC   = 1.0 / 1048576.0;
    localparam real TOL_RAND   = 1.0 / 262144.0;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [1:0]              mode = 2'b00;
    logic                    vectoring = 1'b0;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [WIDTH-1:0] z_in = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] z_out;
    logic                    busy;

    real expX[$];
    real expY[$];
    real expZ[$];
    real expTol[$];
    int  expSteps[$];
    int  acceptQ[$];

    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleCount = 0;
    int   riseCycle  = 0;
    logic prevValid  = 1'b0;

    cordic_iterative_engine #(
        .WIDTH(WIDTH),
        .FRAC(FRAC),
        .ITERATIONS(ITERATIONS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode),
        .vectoring(vectoring),
        .x_in(x_in),
        .y_in(y_in),
        .z_in(z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out(x_out),
        .y_out(y_out),
        .z_out(z_out),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    function automatic real fromFix(input logic signed [31:0] v);
        return $itor(v) / SCALE;
    endfunction

    function automatic logic signed [31:0] toFix(input real r);
        return $rtoi(r * SCALE);
    endfunction

    function automatic real rnd(input real lo, input real hi);
        return lo + (hi - lo) * ($itor($urandom_range(0, 1000000)) / 1000000.0);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input real act, input real expv, input real tol);
        real diff;
        diff = act - expv;
        if (diff < 0.0) diff = -diff;
        checkCount++;
        if (diff <= tol) passCount++;
        else $display("[TB] FAIL %s: got %0.9f expected %0.9f (tol %0.3e)", name, act, expv, tol);
    endtask

    task automatic checkFlag(input string name, input int act, input int expv);
        checkCount++;
        if (act == expv) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Ideal CORDIC result: exact rotation/vectoring scaled by the analytic gain product.
    task automatic model(input logic [1:0] m, input logic v, input real x, input real y, input real z,
                         output real ex, output real ey, output real ez, output int steps);
        real g, p, ch, sh;
        g = 1.0;
        p = 1.0;
        steps = ITERATIONS;
        if (m == 2'b11) begin
            for (int i = 1; i <= ITERATIONS; i++) begin
                p = p * 0.25;
                g = g * $sqrt(1.0 - p);
                if (i == 4 || i == 13 || i == 40) begin
                    g = g * $sqrt(1.0 - p);
                    steps++;
                end
            end
            if (!v) begin
                ch = ($exp(z) + $exp(-z)) / 2.0;
                sh = ($exp(z) - $exp(-z)) / 2.0;
                ex = g * (x * ch + y * sh);
                ey = g * (y * ch + x * sh);
                ez = 0.0;
            end else begin
                ex = g * $sqrt(x * x - y * y);
                ey = 0.0;
                ez = z + 0.5 * $ln((x + y) / (x - y));
            end
        end else if (m == 2'b10) begin
            for (int i = 0; i < ITERATIONS; i++) begin
                g = g * $sqrt(1.0 + p);
                p = p * 0.25;
            end
            if (!v) begin
                ex = g * (x * $cos(z) - y * $sin(z));
                ey = g * (y * $cos(z) + x * $sin(z));
                ez = 0.0;
            end else begin
                ex = g * $sqrt(x * x + y * y);
                ey = 0.0;
                ez = z + $atan2(y, x);
            end
        end else begin
            ex = x;
            if (!v) begin
                ey = y + x * z;
                ez = 0.0;
            end else begin
                ey = 0.0;
                ez = z + y / x;
            end
        end
    endtask

    // Monitor: records accepts and output rise times, pops the scoreboard on each transfer.
    always @(negedge clock) begin
        if (reset) begin
            acceptQ.delete();
            prevValid = 1'b0;
        end else begin
            if (in_valid && in_ready) acceptQ.push_back(cycleCount + 1);
            if (out_valid && !prevValid) riseCycle = cycleCount;
            prevValid = out_valid;
            if (out_valid && out_ready) begin
                if (expX.size() == 0 || acceptQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_result: got x=%0.6f with nothing expected", fromFix(x_out));
                end else begin
                    checkOutput("x_out", fromFix(x_out), expX.pop_front(), expTol[0]);
                    checkOutput("y_out", fromFix(y_out), expY.pop_front(), expTol[0]);
                    checkOutput("z_out", fromFix(z_out), expZ.pop_front(), expTol.pop_front());
                    checkFlag("latency", riseCycle - acceptQ.pop_front(), expSteps.pop_front());
                end
            end
        end
    end

    // Issue one operation, scramble inputs after capture, then drain the result.
    task automatic applyStimulus(input logic [1:0] m, input logic v, input real xr, input real yr,
                                 input real zr, input real tol, input int holdCycles, input bit randReady);
        logic signed [31:0] xf, yf, zf, sx, sy, sz;
        real ex, ey, ez;
        int  steps;
        bit  got, holdOk;
        xf = toFix(xr);
        yf = toFix(yr);
        zf = toFix(zr);
        model(m, v, fromFix(xf), fromFix(yf), fromFix(zf), ex, ey, ez, steps);
        expX.push_back(ex);
        expY.push_back(ey);
        expZ.push_back(ez);
        expTol.push_back(tol);
        expSteps.push_back(steps);
        mode = m;
        vectoring = v;
        x_in = xf;
        y_in = yf;
        z_in = zf;
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        mode = 2'($urandom);
        vectoring = 1'($urandom);
        x_in = $urandom;
        y_in = $urandom;
        z_in = $urandom;
        if (!got) begin
            checkFlag("accept_timeout", 0, 1);
            return;
        end
        got = 1'b0;
        if (holdCycles == 0) begin
            for (int n = 0; n < 300 && !got; n++) begin
                out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) got = 1'b1;
                tick();
            end
        end else begin
            out_ready = 1'b0;
            for (int n = 0; n < 300 && !got; n++) begin
                if (out_valid) got = 1'b1;
                else tick();
            end
            sx = x_out;
            sy = y_out;
            sz = z_out;
            for (int h = 0; h < holdCycles && got; h++) begin
                in_valid = (h % 2 == 0);
                x_in = $urandom;
                tick();
                holdOk = out_valid && !in_ready && busy && x_out == sx && y_out == sy && z_out == sz;
                checkFlag("hold_cycle", int'(holdOk), 1);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
        end
        if (!got) checkFlag("result_timeout", 0, 1);
        else checkFlag("in_ready_after_transfer", int'(in_ready), 1);
    endtask

    initial begin
        #(10 * 60000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] m;
        logic       v;
        real        xr, yr, zr;
        bit         sawValid;

        $display("[TB] reset checks");
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkFlag("reset_x_out", int'(x_out), 0);
        checkFlag("reset_y_out", int'(y_out), 0);
        checkFlag("reset_z_out", int'(z_out), 0);
        checkFlag("reset_out_valid", int'(out_valid), 0);
        checkFlag("reset_busy", int'(busy), 0);
        checkFlag("reset_in_ready", int'(in_ready), 1);

        $display("[TB] directed cases");
        applyStimulus(2'b10, 1'b0, 1.0, 0.0, PI / 4.0, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b10, 1'b1, -1.0, 1.0, 0.0, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b11, 1'b0, 1.0, 0.0, 0.5, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b00, 1'b0, 0.5, 0.0, 0.25, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b00, 1'b1, 0.5, 0.125, 0.0, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b01, 1'b0, -1.25, 0.5, -0.75, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b10, 1'b0, 0.75, -0.5, 2.5, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b10, 1'b0, 0.75, -0.5, -2.5, TOL_SPEC, 0, 1'b0);
        applyStimulus(2'b10, 1'b1, -1.0, -0.5, 0.25, TOL_SPEC, 0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(2'b10, 1'b0, 0.75, -0.5, 1.0, TOL_SPEC, 10, 1'b0);

        $display("[TB] reset mid-operation");
        mode = 2'b10;
        vectoring = 1'b0;
        x_in = toFix(1.0);
        y_in = '0;
        z_in = toFix(0.5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkFlag("busy_after_accept", int'(busy), 1);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        checkFlag("midreset_x_out", int'(x_out), 0);
        checkFlag("midreset_y_out", int'(y_out), 0);
        checkFlag("midreset_z_out", int'(z_out), 0);
        checkFlag("midreset_out_valid", int'(out_valid), 0);
        checkFlag("midreset_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkFlag("postreset_in_ready", int'(in_ready), 1);
        sawValid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (out_valid) sawValid = 1'b1;
            tick();
        end
        checkFlag("no_result_after_reset", int'(sawValid), 0);
        applyStimulus(2'b10, 1'b0, 1.0, 0.0, PI / 4.0, TOL_SPEC, 0, 1'b0);

        $display("[TB] randomized operations");
        for (int t = 0; t < 40; t++) begin
            m = 2'($urandom_range(0, 3));
            v = 1'($urandom_range(0, 1));
            case (m)
                2'b10: begin
                    xr = rnd(-2.0, 2.0);
                    if (!v) begin
                        yr = rnd(-2.0, 2.0);
                        zr = rnd(-3.0, 3.0);
                    end else begin
                        yr = rnd(0.25, 2.0) * (($urandom_range(0, 1) == 0) ? 1.0 : -1.0);
                        zr = rnd(-0.5, 0.5);
                    end
                end
                2'b11: begin
                    if (!v) begin
                        xr = rnd(-1.0, 1.0);
                        yr = rnd(-1.0, 1.0);
                        zr = rnd(-1.0, 1.0);
                    end else begin
                        xr = rnd(0.5, 2.0);
                        yr = xr * rnd(-0.7, 0.7);
                        zr = rnd(-0.5, 0.5);
                    end
                end
                default: begin
                    if (!v) begin
                        xr = rnd(-2.0, 2.0);
                        yr = rnd(-2.0, 2.0);
                        zr = rnd(-1.5, 1.5);
                    end else begin
                        xr = rnd(0.5, 2.0);
                        yr = xr * rnd(-1.5, 1.5);
                        zr = rnd(-0.5, 0.5);
                    end
                end
            endcase
            applyStimulus(m, v, xr, yr, zr, TOL_RAND, 0, 1'b1);
        end

        repeat (3) tick();
        checkFlag("scoreboard_empty", expX.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
